// File: rtl/l1ca_code_ctrl.sv
// l1ca_code_ctrl: code-rate NCO and command sequencer for one L1 C/A code generator channel
//
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   cmd_valid/ready  command handshake (ready depends on state only)
//   cmd_op           0=START, 1=STOP, 2=SLEW, 3=reserved (accepted, ignored)
//   cmd_sv           SV index latched by START
//   cmd_slew         whole chips to advance for SLEW
//   code_rate        NCO frequency control word, sampled every cycle
//   gen_en/clear/sv  drive the code generator
//   gen_epoch        generator is at chip 0
//   chip_strobe      generator advanced one chip last cycle
//   epoch_strobe     generator just entered chip 0 by advancing
//   epoch_count      epochs since the last START, wraps
//   running          RUN, or a slew that will return to RUN
module l1ca_code_ctrl #(
   parameter int NCO_W   = 32,
   parameter int EPOCH_W = 16
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [5:0]         cmd_sv,
   input  logic [9:0]         cmd_slew,
   input  logic [NCO_W-1:0]   code_rate,
   output logic               gen_en,
   output logic               gen_clear,
   output logic [5:0]         gen_sv,
   input  logic               gen_epoch,
   output logic               chip_strobe,
   output logic               epoch_strobe,
   output logic [EPOCH_W-1:0] epoch_count,
   output logic               running
);
   localparam logic [1:0] OP_START = 2'd0;
   localparam logic [1:0] OP_STOP  = 2'd1;
   localparam logic [1:0] OP_SLEW  = 2'd2;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, SLEW} state_t;

   state_t           state;
   logic [NCO_W-1:0] acc;
   logic [NCO_W-1:0] acc_next;
   logic             carry;
   logic [9:0]       slew_cnt;
   logic             ret_run;
   logic             fire;

   assign {carry, acc_next} = {1'b0, acc} + {1'b0, code_rate};
   assign cmd_ready    = (state == IDLE) || (state == RUN);
   assign fire         = cmd_valid && cmd_ready;
   // the NCO carry only advances the generator while running; a slew forces one chip per cycle
   assign gen_en       = (state == SLEW) || ((state == RUN) && carry);
   assign gen_clear    = (state == CLEAR);
   assign running      = (state == RUN) || ((state == SLEW) && ret_run);
   assign epoch_strobe = chip_strobe && gen_epoch;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         acc         <= '0;
         slew_cnt    <= '0;
         ret_run     <= 1'b0;
         gen_sv      <= '0;
         epoch_count <= '0;
         chip_strobe <= 1'b0;
      end else begin
         chip_strobe <= gen_en;
         // a generator advance during CLEAR belongs to the old seed, so the zeroing wins
         if (state == CLEAR)
            epoch_count <= '0;
         else if (epoch_strobe)
            epoch_count <= epoch_count + EPOCH_W'(1);
         unique case (state)
            CLEAR: begin
               acc   <= '0;
               state <= RUN;
            end
            SLEW: begin
               slew_cnt <= slew_cnt - 10'd1;
               if (slew_cnt == 10'd1)
                  state <= ret_run ? RUN : IDLE;
            end
            default: begin
               // STOP holds the phase so a later START/SLEW sees where the NCO stopped
               if ((state == RUN) && !(fire && (cmd_op == OP_STOP)))
                  acc <= acc_next;
               if (fire && (cmd_op == OP_START)) begin
                  gen_sv <= cmd_sv;
                  state  <= CLEAR;
               end else if (fire && (cmd_op == OP_SLEW) && (cmd_slew != '0)) begin
                  slew_cnt <= cmd_slew;
                  ret_run  <= (state == RUN);
                  state    <= SLEW;
               end else if (fire && (cmd_op == OP_STOP)) begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: doc/l1ca_code_ctrl.md
# l1ca_code_ctrl

Sequencer for a single L1 C/A code generator channel. A code-rate NCO produces the generator's chip-advance enable. A small command interface starts, stops, re-seeds or slews the code phase in whole chips. The block emits chip and epoch strobes plus an epoch counter to the correlator and tracking logic, and sits between the channel's tracking-loop register interface and its code generator instance.

## Interface
Parameters:
- NCO_W, 32, code NCO accumulator and FCW width
- EPOCH_W, 16, epoch counter width

Ports:
- clk  in  1  system clock
- nrst  in  1  reset; one clock, reset is asynchronous and active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge
- cmd_op  in  2  0=START, 1=STOP, 2=SLEW, 3=reserved (accepted, no effect)
- cmd_sv  in  6  SV index for START (0..31)
- cmd_slew  in  10  chips to advance for SLEW (0..1023)
- code_rate  in  NCO_W  FCW; chip rate = f_clk * code_rate / 2^NCO_W; sampled every cycle
- gen_en  out  1  to generator en
- gen_clear  out  1  to generator clear
- gen_sv  out  6  to generator sv; latched on START
- gen_epoch  in  1  from generator epoch
- chip_strobe  out  1  generator has advanced one chip; gen_chip now valid
- epoch_strobe  out  1  generator just entered chip 0
- epoch_count  out  EPOCH_W  epochs since last START, wraps
- running  out  1  state is RUN or SLEW-returning-to-RUN

## Operation
- States: IDLE, CLEAR, RUN, SLEW. Register ret_run records the state to return to after a slew.
- IDLE:
  - gen_en=0, cmd_ready=1, NCO held.
  - START latches cmd_sv into gen_sv and goes to CLEAR.
  - SLEW with N>0 sets ret_run=0 and goes to SLEW, which pre-positions the code.
  - STOP, and SLEW with N=0, are no-ops.
- CLEAR (1 cycle):
  - gen_clear=1, gen_en=0, cmd_ready=0.
  - Accumulator and epoch_count are zeroed.
  - Next state is RUN.
- RUN:
  - {carry, acc_next} = acc + code_rate, computed combinationally; acc <= acc_next; gen_en = carry.
  - cmd_ready=1.
  - START re-seeds: latch sv, go to CLEAR.
  - STOP goes to IDLE; acc is held and that cycle's gen_en is still driven.
  - SLEW with N>0 sets ret_run=1 and goes to SLEW.
- SLEW:
  - Load slew_cnt=N on entry. gen_en=1 every cycle, slew_cnt decrements each cycle, NCO is frozen, cmd_ready=0.
  - The cycle with slew_cnt==1 is the last pulse. The next state is RUN if ret_run, else IDLE.
  - N=1023 yields a net phase change of 0 chips but still sends the generator through one epoch.
- chip_strobe is gen_en registered by one cycle, asserted in the same cycle the generator's new state is visible.
- epoch_strobe = chip_strobe && gen_epoch. The clear in CLEAR does not produce an epoch_strobe.
- Slew-generated epochs strobe and count.
- epoch_count increments on epoch_strobe, wrapping 2^EPOCH_W-1 -> 0.
- The block does not reset the generator itself (the generator uses a synchronous reset). Every START issues gen_clear.

## Timing
- Reset values:
  - State IDLE; acc, slew_cnt, ret_run, gen_sv, epoch_count all 0.
  - gen_en, gen_clear, chip_strobe, epoch_strobe, running all 0; cmd_ready=1.
- START accepted at edge T:
  - CLEAR during T..T+1 with gen_clear=1.
  - RUN from T+1.
  - First NCO add in cycle T+1..T+2.
- Latencies:
  - A code_rate change takes effect on the next add.
  - gen_en to chip_strobe is 1 cycle.
- cmd_ready is combinational from state only and never depends on cmd_valid.
- An asynchronous reset asserted mid-SLEW or mid-RUN forces IDLE immediately. Outputs go to reset values without waiting for a clock.

## Test plan
- Reset:
  - Stimulus: assert nrst=0 mid-RUN.
  - Required: gen_en, gen_clear, strobes and epoch_count read 0, and cmd_ready=1, before the next clk edge.
- START:
  - Stimulus: START sv=0 with code_rate=0x8000_0000.
  - Required: gen_clear high exactly 1 cycle; gen_en pulses every 2nd cycle starting at the 2nd RUN cycle; after 1023 pulses epoch_strobe fires once and epoch_count=1.
- Nominal rate:
  - Stimulus: code_rate=0x1000_0000.
  - Required: gen_en every 16 cycles; epoch_strobe every 16368 cycles; epoch_count=3 after 3 epochs.
- SLEW in RUN:
  - Stimulus: SLEW 5 at gen_chip=100.
  - Required: gen_en high 5 consecutive cycles; cmd_ready low 5 cycles; gen_chip=105; acc unchanged across the slew; returns to RUN.
- SLEW across an epoch:
  - Stimulus: SLEW 5 at gen_chip=1020.
  - Required: gen_chip=2 afterward; exactly one epoch_strobe; epoch_count increments by 1.
- STOP then re-seed:
  - Stimulus: STOP, then SLEW 3 in IDLE, then START sv=7.
  - Required: no gen_en after STOP until the slew; the slew gives 3 pulses and returns to IDLE; START gives gen_sv=7, gen_clear for 1 cycle, epoch_count=0, running=1.
